// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: FSM states and line-protocol constants shared by the USB receive path.
package usb_rx_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} rx_state_t;
    localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;
    localparam int STUFF_LEN = 6;
endpackage

// File: rtl/usb_rx_fifo.sv
// usb_rx_fifo: first-word-fall-through FIFO; head reads as 0 while empty, ovf flags a dropped write.
module usb_rx_fifo #(
    parameter int W = 9,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic full, pop, wr;
    always_comb begin
        empty = cnt == '0;
        full = cnt == (AW+1)'(DEPTH);
        pop = rd_en && !empty;
        wr = wr_en && (!full || pop);
        ovf = wr_en && !wr;
        rd_data = empty ? '0 : mem[rp];
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= wr ? wp + AW'(1) : wp;
            rp <= pop ? rp + AW'(1) : rp;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (wr) mem[wp] <= wr_data;
endmodule

// File: rtl/usb_rx_deser.sv
// usb_rx_deser: USB receive deserializer - NRZI decode, sync/EOP detect, bit unstuffing, word packing.
// Define USB_RX_ERR_COUNT_EN to build the saturating err_cnt counter; otherwise err_cnt is tied to 0.
module usb_rx_deser import usb_rx_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic              din,
    input  logic              se0,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_validh,
    input  logic              dout_ready,
    output logic              rx_active,
    output logic              rx_error,
    output logic [7:0]        err_cnt
);
    rx_state_t state, state_n;
    logic prev, se0_d, push_q, empty, ovf;
    logic [6:0] sh;
    logic [7:0] sh_n;
    logic [2:0] ones;
    logic [4:0] bit_cnt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W:0] push_w, push_d, head;
    logic data_stb, dec, sync_det, eop, stuff_slot, stuff_err, take, word_done;
    logic eop_push, eop_err, push, err_ev;
    always_comb begin
        data_stb = din_valid && !se0;
        dec = ~(din ^ prev);
        sh_n = {sh, dec};
        sync_det = state == IDLE && data_stb && sh_n == SYNC_PATTERN;
        eop = din_valid && se0 && se0_d && state != IDLE;
        stuff_slot = state == ACTIVE && data_stb && ones == 3'(STUFF_LEN);
        stuff_err = stuff_slot && dec;
        take = state == ACTIVE && data_stb && !stuff_slot;
        word_done = take && bit_cnt == 5'(DATA_W - 1);
        eop_push = eop && state == ACTIVE && DATA_W == 16 && bit_cnt == 5'd8;
        eop_err = eop && state == ACTIVE && bit_cnt != '0 && !eop_push;
        push = word_done || eop_push;
        // a lone trailing byte sits in the top half of the shift register
        push_w = eop_push ? {1'b0, sr >> 8} : {1'(DATA_W == 16), dec, sr[DATA_W-1:1]};
        err_ev = stuff_err || eop_err || ovf;
        state_n = state == IDLE ? (sync_det ? ACTIVE : IDLE) :
                  state == ACTIVE ? (stuff_err ? ERROR : eop ? IDLE : ACTIVE) :
                  (eop ? IDLE : ERROR);
    end
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= 1'b1;
            se0_d <= 1'b0;
            sh <= '1;
            ones <= '0;
            bit_cnt <= '0;
            sr <= '0;
            push_q <= 1'b0;
            push_d <= '0;
            rx_error <= 1'b0;
        end else begin
            prev <= eop || (state == IDLE && din_valid && se0) ? 1'b1 : data_stb ? din : prev;
            se0_d <= din_valid ? se0 && !eop : se0_d;
            sh <= state != IDLE || (din_valid && se0) ? '1 : data_stb ? sh_n[6:0] : sh;
            ones <= sync_det || stuff_slot || eop || (take && !dec) ? '0 : take ? ones + 3'd1 : ones;
            bit_cnt <= sync_det || eop || word_done ? '0 : take ? bit_cnt + 5'd1 : bit_cnt;
            sr <= take ? {dec, sr[DATA_W-1:1]} : sr;
            push_q <= push;
            push_d <= push_w;
            rx_error <= err_ev || (rx_error && !sync_det);
        end
    end
`ifdef USB_RX_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            err_cnt <= '0;
        else if (err_ev && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = '0;
`endif
    usb_rx_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(push_q),
        .wr_data(push_d),
        .rd_en(dout_ready),
        .rd_data(head),
        .empty(empty),
        .ovf(ovf)
    );
    assign dout = head[DATA_W-1:0];
    assign dout_validh = head[DATA_W];
    assign dout_valid = !empty;
    assign rx_active = state == ACTIVE;
endmodule

// File: tb/tb_usb_rx_deser.sv
// tb_usb_rx_deser: scoreboard bench for three configurations (8-bit, 16-bit, 8-bit with 4-deep FIFO).
module tb_usb_rx_deser;
`ifdef USB_RX_ERR_COUNT_EN
    localparam int EC = 1;
`else
    localparam int EC = 0;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic [2:0] rst_v, dv, di, s0, rdy, v, vh, act, err;
    logic [7:0] d0, d2, ec0, ec1, ec2;
    logic [15:0] d1;
    int tests = 0, fails = 0;
    int lvl[3], ones[3];
    logic [16:0] q0[$], q1[$], q2[$];

    usb_rx_deser u8 (.clk(clk), .rst(rst_v[0]), .din_valid(dv[0]), .din(di[0]), .se0(s0[0]),
        .dout(d0), .dout_valid(v[0]), .dout_validh(vh[0]), .dout_ready(rdy[0]),
        .rx_active(act[0]), .rx_error(err[0]), .err_cnt(ec0));
    usb_rx_deser #(.DATA_W(16)) u16 (.clk(clk), .rst(rst_v[1]), .din_valid(dv[1]), .din(di[1]),
        .se0(s0[1]), .dout(d1), .dout_valid(v[1]), .dout_validh(vh[1]), .dout_ready(rdy[1]),
        .rx_active(act[1]), .rx_error(err[1]), .err_cnt(ec1));
    usb_rx_deser #(.FIFO_DEPTH(4)) u4 (.clk(clk), .rst(rst_v[2]), .din_valid(dv[2]), .din(di[2]),
        .se0(s0[2]), .dout(d2), .dout_valid(v[2]), .dout_validh(vh[2]), .dout_ready(rdy[2]),
        .rx_active(act[2]), .rx_error(err[2]), .err_cnt(ec2));

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask
    task automatic sb(input string n, input logic [16:0] got, input int sz, input logic [16:0] exp);
        tests++;
        if (sz == 0) begin
            fails++;
            $display("FAIL %s: unexpected word %0h, nothing expected", n, got);
        end else if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    int n0, n1, n2;
    logic [16:0] e0, e1, e2;
    always @(negedge clk) begin
        if (v[0] && rdy[0]) begin
            n0 = q0.size();
            e0 = n0 != 0 ? q0.pop_front() : '0;
            sb("u8_word", {vh[0], 8'h00, d0}, n0, e0);
        end
        if (v[1] && rdy[1]) begin
            n1 = q1.size();
            e1 = n1 != 0 ? q1.pop_front() : '0;
            sb("u16_word", {vh[1], d1}, n1, e1);
        end
        if (v[2] && rdy[2]) begin
            n2 = q2.size();
            e2 = n2 != 0 ? q2.pop_front() : '0;
            sb("u4_word", {vh[2], 8'h00, d2}, n2, e2);
        end
    end

    // drive one strobe carrying decoded bit b (NRZI: 0 toggles the line) or an se0
    task automatic line(input int k, input bit s, input bit b);
        if (!s && !b) lvl[k] = 1 - lvl[k];
        dv[k] = 1'b1;
        s0[k] = s;
        di[k] = s ? 1'b0 : lvl[k] != 0;
        @(posedge clk);
        #1;
        dv[k] = 1'b0;
    endtask
    task automatic dbit(input int k, input bit b);
        line(k, 1'b0, b);
        ones[k] = b ? ones[k] + 1 : 0;
        if (ones[k] == 6) begin
            line(k, 1'b0, 1'b0);
            ones[k] = 0;
        end
    endtask
    task automatic byte_tx(input int k, input logic [7:0] x);
        for (int i = 0; i < 8; i++) dbit(k, x[i]);
    endtask
    task automatic sync(input int k);
        line(k, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) line(k, 1'b0, 1'b0);
        line(k, 1'b0, 1'b1);
        ones[k] = 0;
    endtask
    task automatic eop(input int k);
        line(k, 1'b1, 1'b0);
        line(k, 1'b1, 1'b0);
        lvl[k] = 1;
        line(k, 1'b0, 1'b1);
    endtask

    initial begin
        rst_v = '0;
        dv = '0;
        di = '1;
        s0 = '0;
        rdy = 3'b011;
        for (int i = 0; i < 3; i++) begin
            lvl[i] = 1;
            ones[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", d0, 0);
        chk("rst_valid", v, 0);
        chk("rst_validh", vh, 0);
        chk("rst_active", act, 0);
        chk("rst_error", err, 0);
        chk("rst_errcnt", ec0, 0);
        rst_v = '1;
        @(posedge clk);
        #1;
        // A5, 3C, EOP
        sync(0);
        chk("active_after_sync", act[0], 1);
        byte_tx(0, 8'hA5);
        q0.push_back(17'h000A5);
        chk("latency_plus1", v[0], 0);
        @(posedge clk);
        #1;
        chk("latency_plus2", v[0], 1);
        byte_tx(0, 8'h3C);
        q0.push_back(17'h0003C);
        eop(0);
        chk("a_active_after_eop", act[0], 0);
        chk("a_error", err[0], 0);
        // stuffed payload FF 7E
        sync(0);
        byte_tx(0, 8'hFF);
        q0.push_back(17'h000FF);
        byte_tx(0, 8'h7E);
        q0.push_back(17'h0007E);
        eop(0);
        chk("b_error", err[0], 0);
        // seven ones -> ERROR, later data ignored
        sync(0);
        for (int i = 0; i < 7; i++) line(0, 1'b0, 1'b1);
        chk("c_error", err[0], 1);
        chk("c_active", act[0], 0);
        byte_tx(0, 8'h55);
        eop(0);
        chk("c_active_after_eop", act[0], 0);
        chk("c_error_sticky", err[0], 1);
        chk("c_errcnt", ec0, EC);
        // sync clears error; misaligned residue errors at EOP
        sync(0);
        chk("d_error_cleared", err[0], 0);
        byte_tx(0, 8'h12);
        q0.push_back(17'h00012);
        dbit(0, 1'b1);
        dbit(0, 1'b0);
        dbit(0, 1'b1);
        eop(0);
        chk("d_residue_error", err[0], 1);
        chk("d_errcnt", ec0, 2 * EC);
        // 16-bit words with a trailing lone byte
        sync(1);
        byte_tx(1, 8'h11);
        byte_tx(1, 8'h22);
        q1.push_back(17'h12211);
        byte_tx(1, 8'h33);
        q1.push_back(17'h00033);
        eop(1);
        chk("e_error", err[1], 0);
        chk("e_active", act[1], 0);
        // 4-deep FIFO overflow, then reset mid-packet
        sync(2);
        for (int b = 1; b <= 5; b++) byte_tx(2, 8'(b));
        repeat (3) @(posedge clk);
        #1;
        chk("f_overflow_error", err[2], 1);
        chk("f_head_valid", v[2], 1);
        chk("f_head", d2, 8'h01);
        chk("f_active", act[2], 1);
        chk("f_errcnt", ec2, EC);
        for (int b = 1; b <= 4; b++) q2.push_back(17'(b));
        rdy[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rdy[2] = 1'b0;
        chk("f_drained", v[2], 0);
        byte_tx(2, 8'h06);
        repeat (3) @(posedge clk);
        #1;
        chk("f_held", v[2], 1);
        rst_v[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("g_rst_valid", v[2], 0);
        chk("g_rst_dout", d2, 0);
        chk("g_rst_validh", vh[2], 0);
        chk("g_rst_active", act[2], 0);
        chk("g_rst_error", err[2], 0);
        chk("g_rst_errcnt", ec2, 0);
        rst_v[2] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("q8_drained", q0.size(), 0);
        chk("q16_drained", q1.size(), 0);
        chk("q4_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/usb_rx_deser.md
USB_RX_DESER -- requirements
Module: usb_rx_deser

Interface
REQ-001 SHALL have parameter DATA_W, default 8, receive word width; legal values 8 and 16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries; power of 2, >= 4.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din_valid  input  1  line-bit sample strobe, at most 1 per clk.
REQ-006 SHALL have port din  input  1  sampled differential line bit (J=1, K=0), qualified by din_valid.
REQ-007 SHALL have port se0  input  1  single-ended-zero line state, qualified by din_valid.
REQ-008 SHALL have port dout  output  DATA_W  received word, LSB = first bit received.
REQ-009 SHALL have port dout_valid  output  1  dout holds a valid FIFO head word.
REQ-010 SHALL have port dout_validh  output  1  upper byte of dout valid; constant 0 when DATA_W=8.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts the word; pop when dout_valid && dout_ready.
REQ-012 SHALL have port rx_active  output  1  high from sync detect until EOP or error.
REQ-013 SHALL have port rx_error  output  1  sticky error flag, cleared on the next sync detect.
REQ-014 SHALL have port err_cnt  output  8  error counter (see Configuration).

Function
REQ-015 SHALL NRZI-decode each strobed bit: decoded = ~(din ^ prev); prev updates on every strobe; prev reloads to 1 in IDLE.
REQ-016 SHALL implement FSM states IDLE, ACTIVE, ERROR; IDLE->ACTIVE when the last 8 decoded bits, oldest first, are 0000_0001.
REQ-017 SHALL, in ACTIVE, discard the decoded bit that follows six consecutive decoded 1s; if that bit is 1, set rx_error and go to ERROR.
REQ-018 SHALL pack non-stuffed decoded bits LSB-first; push a word to the FIFO when DATA_W bits are collected.
REQ-019 SHALL detect EOP as se0 high on 2 consecutive strobes in ACTIVE -> IDLE; se0 strobes are not decoded as data.
REQ-020 SHALL, at EOP with DATA_W=16 and exactly 8 residual bits, push the word with validh=0 and upper byte 0.
REQ-021 SHALL, at EOP with a non-byte-aligned residue, discard the residue and set rx_error.
REQ-022 SHALL, on push while the FIFO is full (and no simultaneous pop), drop the word and set rx_error; push+pop when full SHALL both succeed.
REQ-023 SHALL present the FIFO first-word-fall-through: dout_valid rises exactly 2 clk after the strobe carrying the word's last bit.
REQ-024 SHALL leave ERROR for IDLE on the first EOP; no pushes occur in ERROR.
REQ-025 SHALL keep rx_active = (state == ACTIVE).

Reset
REQ-026 SHALL, while rst==0 at posedge clk, force IDLE, empty the FIFO, and set dout=0, dout_valid=0, dout_validh=0, rx_active=0, rx_error=0, err_cnt=0, prev=1; this applies mid-packet too.

Configuration
REQ-027 SHALL, with macro USB_RX_ERR_COUNT_EN defined, increment err_cnt by 1 on each rx_error set event, saturating at 255 and cleared only by reset; without the macro, err_cnt SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-028 SHALL place in package usb_rx_pkg: FSM state enum, SYNC_PATTERN = 8'b0000_0001 constant, STUFF_LEN = 6 constant.
REQ-029 SHALL implement the FIFO as sub-module usb_rx_fifo (params DATA_W+1 wide incl. validh, FIFO_DEPTH).

Verification
REQ-030 SHALL cover: sync then bytes 0xA5, 0x3C, then EOP at DATA_W=8 -> dout 0xA5 then 0x3C, rx_error=0, rx_active falls after EOP.
REQ-031 SHALL cover: payload 0xFF 0x7E with a stuffed 0 after six 1s -> dout 0xFF, 0x7E; stuffed bit is absent from the data.
REQ-032 SHALL cover: seven consecutive decoded 1s -> rx_error=1, ERROR state, no further pushes, err_cnt=1 with the macro.
REQ-033 SHALL cover: DATA_W=16 with 3 bytes 0x11 0x22 0x33 -> words 0x2211 (validh=1) and 0x0033 (validh=0).
REQ-034 SHALL cover: FIFO_DEPTH=4, dout_ready=0, 5 bytes -> 4 words held, rx_error=1; reset mid-packet -> all outputs 0 next clk.
